// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and constants for the FIR output chain. The *_DEF widths are
// the defaults used by fir_output_formatter; SAT_MAX/SAT_MIN/ROUND_HALF are
// derived from them for blocks and models that work at the default widths.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int ACC_WIDTH_DEF  = 32;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int FRAC_SHIFT_DEF = 15;

  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;
  typedef logic signed [OUT_WIDTH_DEF-1:0] samp_t;

  // Largest / smallest representable formatted sample.
  localparam samp_t SAT_MAX = {1'b0, {(OUT_WIDTH_DEF-1){1'b1}}};
  localparam samp_t SAT_MIN = {1'b1, {(OUT_WIDTH_DEF-1){1'b0}}};

  // Half an output LSB expressed in accumulator units.
  localparam acc_t ROUND_HALF = acc_t'(1) << (FRAC_SHIFT_DEF - 1);

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port. The head entry appears on
// rd_valid_o/rd_data_o one cycle after it is written; a pop happens when
// rd_valid_o && pop_i. A push while full is ignored unless a pop happens in
// the same cycle, in which case both complete.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i/push_data_i write strobe and data
//   pop_i             consumer ready
//   rd_valid_o/rd_data_o registered head of queue
//   full_o/empty_o    occupancy flags
//   count_o           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   rd_valid_o,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      remain;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_pop, do_push;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    do_pop     = rd_valid_q && pop_i;
    do_push    = push_i && (!full_o || do_pop);
    // Entries that were already stored before this edge and survive the pop;
    // only these may be presented next cycle, giving the one-cycle read latency.
    remain     = count_q - (AW+1)'(do_pop);
    count_d    = remain + (AW+1)'(do_push);
    wr_ptr_d   = wr_ptr_q + AW'(do_push);
    rd_ptr_d   = rd_ptr_q + AW'(do_pop);
    rd_valid_d = (remain != '0);
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // NOTE: storage is not reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fir_output_formatter.sv
// -----------------------------------------------------------------------------
// fir_output_formatter
// Last stage of the FIR filter: optional 1-of-DECIM decimation, round half-up
// and saturate to OUT_WIDTH, then buffer in a FIFO that drives a valid/ready
// stream. Tracks clipped samples (saturating counter) and a sticky flag for
// kept samples lost because the FIFO was full.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_data   FIR sample strobe and signed sample (no backpressure)
//   out_valid, out_ready, out_data  registered output stream
//   clr_status          clears sat_count and overflow
//   sat_count           number of clipped samples, sticks at 16'hFFFF
//   overflow            sticky drop flag
// -----------------------------------------------------------------------------
module fir_output_formatter
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 clr_status,
  output logic [15:0]          sat_count,
  output logic                 overflow
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Rounding and clamp limits at the extended (ACC_WIDTH+1) precision.
  localparam logic signed [ACC_WIDTH:0] RND_HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] CLIP_HI =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] CLIP_LO =
    {{(ACC_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [PH_W-1:0]             phase_q, phase_d;
  logic                        keep;
  logic signed [ACC_WIDTH:0]   ext_s, sum_s, shr_s;
  logic                        s1_valid_q, s1_valid_d;
  logic [OUT_WIDTH-1:0]        s1_data_q, s1_data_d;
  logic                        s1_sat_q, s1_sat_d;
  logic [15:0]                 sat_count_q, sat_count_d;
  logic                        overflow_q, overflow_d;
  logic                        fifo_full, pop, sat_ev, ovf_ev;
  logic                        unused_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_count;

  // Decimation phase and round/saturate (stage-1 next state).
  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
    keep = in_valid && (phase_q == '0);

    // The extra top bit keeps the +half addition from wrapping.
    ext_s = {in_data[ACC_WIDTH-1], in_data};
    sum_s = ext_s + RND_HALF;
    shr_s = sum_s >>> FRAC_SHIFT;

    s1_valid_d = keep;
    s1_data_d  = s1_data_q;
    s1_sat_d   = s1_sat_q;
    if (keep) begin
      if (shr_s > CLIP_HI) begin
        s1_data_d = OUT_MAX;
        s1_sat_d  = 1'b1;
      end else if (shr_s < CLIP_LO) begin
        s1_data_d = OUT_MIN;
        s1_sat_d  = 1'b1;
      end else begin
        s1_data_d = shr_s[OUT_WIDTH-1:0];
        s1_sat_d  = 1'b0;
      end
    end
  end

  // Status: events are counted when the stage-1 result is handed to the FIFO,
  // so a clear in that same cycle still records the event.
  always_comb begin
    pop    = out_valid && out_ready;
    sat_ev = s1_valid_q && s1_sat_q;
    ovf_ev = s1_valid_q && fifo_full && !pop;

    sat_count_d = sat_count_q;
    overflow_d  = overflow_q || ovf_ev;
    if (clr_status) begin
      sat_count_d = {15'd0, sat_ev};
      overflow_d  = ovf_ev;
    end else if (sat_ev && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sat_q    <= 1'b0;
      sat_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sat_q    <= s1_sat_d;
      sat_count_q <= sat_count_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s1_valid_q),
    .push_data_i (s1_data_q),
    .pop_i       (out_ready),
    .rd_valid_o  (out_valid),
    .rd_data_o   (out_data),
    .full_o      (fifo_full),
    .empty_o     (unused_empty),
    .count_o     (unused_count)
  );

  assign sat_count = sat_count_q;
  assign overflow  = overflow_q;

endmodule
